// File: rtl/mips_mc_ctrl_hs_if.sv
// ============================================================================
// Module      : mips_mc_ctrl_hs_if
// Description : Bundle between the multicycle MIPS controller and the
//               datapath/memory. The master side is the controller. It
//               takes the instruction fields, the zero flag and memready,
//               and it drives every control strobe plus the debug outputs.
//               The slave side is the datapath/memory.
// Ports       : op[5:0], funct[5:0], zero, memready      (to controller)
//               memwrite, lord, irwrite, regdst, memtoreg, regwrite,
//               alusrca, alusrcb[1:0], alucontrol[ALUCTL_W-1:0], pcen,
//               pcsrc[1:0], immsrc, state[3:0], illegal, memerr
//                                                        (from controller)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_mc_ctrl_hs_if #(
  parameter int ALUCTL_W = 3
);
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                memready;
  logic                memwrite;
  logic                lord;
  logic                irwrite;
  logic                regdst;
  logic                memtoreg;
  logic                regwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [ALUCTL_W-1:0] alucontrol;
  logic                pcen;
  logic [1:0]          pcsrc;
  logic                immsrc;
  logic [3:0]          state;
  logic                illegal;
  logic                memerr;

  modport master (
    input  op, funct, zero, memready,
    output memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, alucontrol, pcen, pcsrc, immsrc, state, illegal, memerr
  );

  modport slave (
    output op, funct, zero, memready,
    input  memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, alucontrol, pcen, pcsrc, immsrc, state, illegal, memerr
  );
endinterface

`default_nettype wire

// File: rtl/mips_mc_ctrl_hs.sv
// ============================================================================
// Module      : mips_mc_ctrl_hs
// Description : Multicycle MIPS control unit. It contains the main FSM and
//               the ALU decoder. It adds a memready wait handshake with a
//               bounded-wait timeout that sets a sticky memerr flag. It also
//               supports bne, addi and j, and it reports illegal op/funct.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous reset, active low
//               bus   - mips_mc_ctrl_hs_if.master (instruction fields,
//                       zero, memready in; control strobes, state, illegal,
//                       memerr out)
// Options     : MC_IMM_LOGIC_EN - when defined, decode andi/ori into the
//               ANDIEX/ORIEX states, which select the zero-extended
//               immediate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_ctrl_hs #(
  parameter int ALUCTL_W = 3,
  parameter int MAX_WAIT = 15
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mips_mc_ctrl_hs_if.master   bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_BNE     = 4'd12;
  localparam logic [3:0] S_ANDIEX  = 4'd13;
  localparam logic [3:0] S_ORIEX   = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // At least one bit, so that MAX_WAIT=0 (never time out) still elaborates.
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             memerr_q, memerr_d;

  logic [3:0] dec_state;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       waiting;
  logic       timeout;

  // Opcode decode target. FETCH doubles as "illegal opcode".
  always_comb begin
    dec_state = S_FETCH;
    case (bus.op)
      OP_LW, OP_SW: dec_state = S_MEMADR;
      OP_RTYPE:     dec_state = S_EXECUTE;
      OP_BEQ:       dec_state = S_BEQ;
      OP_BNE:       dec_state = S_BNE;
      OP_ADDI:      dec_state = S_ADDIEX;
      OP_J:         dec_state = S_JUMP;
`ifdef MC_IMM_LOGIC_EN
      OP_ANDI:      dec_state = S_ANDIEX;
      OP_ORI:       dec_state = S_ORIEX;
`endif
      default:      dec_state = S_FETCH;
    endcase
  end

  // R-type ALU decoder.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = (MAX_WAIT > 0) && (wait_q == C_WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      memerr_q <= memerr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = S_FETCH;
    wait_d   = '0;
    memerr_d = memerr_q;
    case (state_q)
      S_FETCH:   state_d = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = dec_state;
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = bus.memready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = funct_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX:  state_d = S_IMMWB;
`ifdef MC_IMM_LOGIC_EN
      S_ANDIEX, S_ORIEX: state_d = S_IMMWB;
`endif
      default:   state_d = S_FETCH;
    endcase
    // Stalled memory access. Count the stall, or abort it back to FETCH
    // once the wait bound is hit.
    if (waiting && !bus.memready) begin
      if (timeout) begin
        memerr_d = 1'b1;
        state_d  = S_FETCH;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
  end

  // Output logic.
  logic       o_memwrite, o_lord, o_irwrite, o_regdst, o_memtoreg, o_regwrite;
  logic       o_alusrca, o_pcwrite, o_beq, o_bne, o_immsrc, o_illegal;
  logic [1:0] o_alusrcb, o_pcsrc;
  logic [2:0] o_alu;

  always_comb begin
    o_memwrite = 1'b0;
    o_lord     = 1'b0;
    o_irwrite  = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_regwrite = 1'b0;
    o_alusrca  = 1'b0;
    o_pcwrite  = 1'b0;
    o_beq      = 1'b0;
    o_bne      = 1'b0;
    o_immsrc   = 1'b0;
    o_illegal  = 1'b0;
    o_alusrcb  = 2'b00;
    o_pcsrc    = 2'b00;
    o_alu      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        o_alusrcb = 2'b01;
        o_irwrite = bus.memready;
        o_pcwrite = bus.memready;
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        o_illegal = (dec_state == S_FETCH);
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      S_MEMRD: o_lord = 1'b1;
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_lord     = 1'b1;
        o_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        o_alusrca = 1'b1;
        o_alu     = funct_alu;
        o_illegal = !funct_ok;
      end
      S_ALUWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        o_alusrca = 1'b1;
        o_alu     = ALU_SUB;
        o_pcsrc   = 2'b01;
        o_beq     = (state_q == S_BEQ);
        o_bne     = (state_q == S_BNE);
      end
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      S_IMMWB: o_regwrite = 1'b1;
      S_JUMP: begin
        o_pcsrc   = 2'b10;
        o_pcwrite = 1'b1;
      end
`ifdef MC_IMM_LOGIC_EN
      S_ANDIEX, S_ORIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_immsrc  = 1'b1;
        o_alu     = (state_q == S_ANDIEX) ? ALU_AND : ALU_OR;
      end
`endif
      default: ;
    endcase
  end

  // The write strobes are gated by reset. A reset in the middle of an
  // instruction then issues no further write.
  assign bus.memwrite   = reset & o_memwrite;
  assign bus.irwrite    = reset & o_irwrite;
  assign bus.regwrite   = reset & o_regwrite;
  assign bus.pcen       = reset & (o_pcwrite | (o_beq & bus.zero) | (o_bne & ~bus.zero));
  assign bus.lord       = o_lord;
  assign bus.regdst     = o_regdst;
  assign bus.memtoreg   = o_memtoreg;
  assign bus.alusrca    = o_alusrca;
  assign bus.alusrcb    = o_alusrcb;
  assign bus.alucontrol = ALUCTL_W'(o_alu);
  assign bus.pcsrc      = o_pcsrc;
  assign bus.immsrc     = o_immsrc;
  assign bus.illegal    = o_illegal;
  assign bus.state      = state_q;
  assign bus.memerr     = memerr_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl_hs.sv
// ============================================================================
// Module      : tb_mips_mc_ctrl_hs
// Description : Self-checking bench for mips_mc_ctrl_hs. It runs directed
//               instruction scenarios and then a randomized instruction and
//               memready stream. Every cycle is compared against a table-
//               driven behavioural model. Honours MC_IMM_LOGIC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_ctrl_hs;
  localparam int ALUCTL_W = 4;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mips_mc_ctrl_hs_if #(.ALUCTL_W(ALUCTL_W)) bus ();

  mips_mc_ctrl_hs #(.ALUCTL_W(ALUCTL_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       immsrc, illegal, memerr;
  } ctl_t;

  // Reference model: spec tables plus a few state variables.
  int dec_map   [logic [5:0]];  // opcode -> state entered after DECODE
  int funct_map [logic [5:0]];  // funct  -> alucontrol code
  int m_st, m_wait;
  bit m_err;

  // Per-instruction traces used for the directed checks.
  int tr_st[$];
  int tr_alu[$];
  bit tr_pcen[$];
  bit tr_imm[$];
  int cnt_mw, cnt_rw, cnt_ir, cnt_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_out(output ctl_t e, output logic [31:0] ea);
    int alu;
    e   = '0;
    alu = 2;
    case (m_st)
      0:  begin e.alusrcb = 2'b01; e.irwrite = bus.memready; e.pcen = bus.memready; end
      1:  begin e.alusrcb = 2'b11; e.illegal = !dec_map.exists(bus.op); end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.lord = 1;
      4:  begin e.memtoreg = 1; e.regwrite = 1; end
      5:  begin e.lord = 1; e.memwrite = 1; end
      6:  begin
            e.alusrca = 1;
            if (funct_map.exists(bus.funct)) alu = funct_map[bus.funct];
            else e.illegal = 1;
          end
      7:  begin e.regdst = 1; e.regwrite = 1; end
      8:  begin e.alusrca = 1; alu = 6; e.pcsrc = 2'b01; e.pcen = bus.zero; end
      12: begin e.alusrca = 1; alu = 6; e.pcsrc = 2'b01; e.pcen = !bus.zero; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
`ifdef MC_IMM_LOGIC_EN
      13: begin e.alusrca = 1; e.alusrcb = 2'b10; e.immsrc = 1; alu = 0; end
      14: begin e.alusrca = 1; e.alusrcb = 2'b10; e.immsrc = 1; alu = 1; end
`endif
      default: ;
    endcase
    e.memerr = m_err;
    if (!reset) begin
      e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.pcen = 0;
    end
    ea = 32'(alu);
  endtask

  task automatic model_step();
    bit waiting = (m_st == 0) || (m_st == 3) || (m_st == 5);
    if (waiting && !bus.memready) begin
      // This zero-memready cycle would be consecutive stall number m_wait+1.
      if (MAX_WAIT > 0 && m_wait + 1 == MAX_WAIT) begin
        m_err = 1; m_st = 0; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      case (m_st)
        0:  m_st = 1;
        1:  m_st = dec_map.exists(bus.op) ? dec_map[bus.op] : 0;
        2:  m_st = (bus.op == 6'b101011) ? 5 : 3;
        3:  m_st = 4;
        6:  m_st = funct_map.exists(bus.funct) ? 7 : 0;
        9, 13, 14: m_st = 10;
        default: m_st = 0;
      endcase
    end
  endtask

  function automatic logic [31:0] dut_ctl();
    ctl_t c;
    c = {bus.memwrite, bus.lord, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
         bus.alusrca, bus.alusrcb, bus.pcen, bus.pcsrc, bus.immsrc, bus.illegal, bus.memerr};
    return 32'(c);
  endfunction

  // One clock: compare at the negedge, then advance the model at the posedge.
  task automatic tick();
    ctl_t        e;
    logic [31:0] ea;
    @(negedge clk);
    model_out(e, ea);
    check_eq("state", 32'(bus.state), 32'(m_st));
    check_eq("ctl", dut_ctl(), 32'(e));
    check_eq("alucontrol", 32'(bus.alucontrol), ea);
    tr_st.push_back(int'(bus.state));
    tr_alu.push_back(int'(bus.alucontrol));
    tr_pcen.push_back(bus.pcen);
    tr_imm.push_back(bus.immsrc);
    cnt_mw  += int'(bus.memwrite);
    cnt_rw  += int'(bus.regwrite);
    cnt_ir  += int'(bus.irwrite);
    cnt_ill += int'(bus.illegal);
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic clear_trace();
    tr_st.delete(); tr_alu.delete(); tr_pcen.delete(); tr_imm.delete();
    cnt_mw = 0; cnt_rw = 0; cnt_ir = 0; cnt_ill = 0;
  endtask

  // Run one instruction from FETCH back to FETCH. memready is held low for
  // stall_n cycles of state stall_st and is high otherwise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int stall_st, input int stall_n);
    int  stalled = 0;
    int  n       = 0;
    bit  left    = 0;
    clear_trace();
    bus.op = op; bus.funct = fn; bus.zero = z;
    while (!(left && m_st == 0) && n < 64) begin
      bus.memready = !(m_st == stall_st && stalled < stall_n);
      if (m_st == stall_st && stalled < stall_n) stalled++;
      tick();
      if (m_st != 0) left = 1;
      n++;
    end
    check_eq("instr_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    m_st = 0; m_wait = 0; m_err = 0;
    repeat (cycles) tick();
    reset = 1'b1;
  endtask

  initial begin
    dec_map[6'b100011] = 2;  dec_map[6'b101011] = 2;  dec_map[6'b000000] = 6;
    dec_map[6'b000100] = 8;  dec_map[6'b000101] = 12; dec_map[6'b001000] = 9;
    dec_map[6'b000010] = 11;
`ifdef MC_IMM_LOGIC_EN
    dec_map[6'b001100] = 13; dec_map[6'b001101] = 14;
`endif
    funct_map[6'b100000] = 2; funct_map[6'b100010] = 6; funct_map[6'b100100] = 0;
    funct_map[6'b100101] = 1; funct_map[6'b101010] = 7;

    bus.op = 6'b100011; bus.funct = 6'b100000; bus.zero = 1'b0; bus.memready = 1'b1;
    reset = 1'b0;
    apply_reset(2);
    check_eq("reset_state", 32'(bus.state), 32'd0);
    check_eq("reset_memerr", 32'(bus.memerr), 32'd0);

    // lw with no stalls: 0,1,2,3,4.
    run_instr(6'b100011, 6'b0, 1'b0, -1, 0);
    check_eq("lw_len", 32'(tr_st.size()), 32'd5);
    for (int i = 0; i < 5 && i < tr_st.size(); i++) check_eq("lw_state", 32'(tr_st[i]), 32'(i));
    check_eq("lw_regwrite_cnt", 32'(cnt_rw), 32'd1);
    check_eq("lw_irwrite_cnt", 32'(cnt_ir), 32'd1);

    // sw stalled 3 cycles in MEMWR: memwrite held 4 cycles.
    run_instr(6'b101011, 6'b0, 1'b0, 5, 3);
    check_eq("sw_memwrite_cycles", 32'(cnt_mw), 32'd4);
    check_eq("sw_memerr", 32'(bus.memerr), 32'd0);

    // beq and bne with zero=1.
    run_instr(6'b000100, 6'b0, 1'b1, -1, 0);
    if (tr_st.size() > 2) check_eq("beq_pcen", 32'(tr_pcen[2]), 32'd1);
    run_instr(6'b000101, 6'b0, 1'b1, -1, 0);
    if (tr_st.size() > 2) check_eq("bne_pcen", 32'(tr_pcen[2]), 32'd0);

    // slt, then an undefined funct.
    run_instr(6'b000000, 6'b101010, 1'b0, -1, 0);
    if (tr_alu.size() > 2) check_eq("slt_alu", 32'(tr_alu[2]), 32'd7);
    check_eq("slt_regwrite", 32'(cnt_rw), 32'd1);
    run_instr(6'b000000, 6'b000111, 1'b0, -1, 0);
    check_eq("badfn_illegal", 32'(cnt_ill), 32'd1);
    check_eq("badfn_regwrite", 32'(cnt_rw), 32'd0);
    check_eq("badfn_len", 32'(tr_st.size()), 32'd3);

    // lw timing out in MEMRD after MAX_WAIT stalls; memerr stays sticky.
    run_instr(6'b100011, 6'b0, 1'b0, 3, MAX_WAIT);
    check_eq("timeout_memerr", 32'(bus.memerr), 32'd1);
    check_eq("timeout_regwrite", 32'(cnt_rw), 32'd0);
    check_eq("timeout_len", 32'(tr_st.size()), 32'(3 + MAX_WAIT));
    run_instr(6'b001000, 6'b0, 1'b0, 0, 2);
    check_eq("memerr_sticky", 32'(bus.memerr), 32'd1);
    run_instr(6'b000010, 6'b0, 1'b0, -1, 0);

    // ori: feature-dependent.
    run_instr(6'b001101, 6'b0, 1'b0, -1, 0);
`ifdef MC_IMM_LOGIC_EN
    if (tr_st.size() > 3) begin
      check_eq("ori_state", 32'(tr_st[2]), 32'd14);
      check_eq("ori_alu", 32'(tr_alu[2]), 32'd1);
      check_eq("ori_immsrc", 32'(tr_imm[2]), 32'd1);
      check_eq("ori_wb_state", 32'(tr_st[3]), 32'd10);
    end
    check_eq("ori_regwrite", 32'(cnt_rw), 32'd1);
`else
    check_eq("ori_illegal", 32'(cnt_ill), 32'd1);
    check_eq("ori_len", 32'(tr_st.size()), 32'd2);
`endif

    // Reset asserted during a stalled store: no write while reset is low.
    bus.op = 6'b101011; bus.memready = 1'b1;
    for (int i = 0; i < 8 && m_st != 5; i++) tick();
    bus.memready = 1'b0;
    tick();
    clear_trace();
    apply_reset(1);
    check_eq("rst_mid_memwrite", 32'(cnt_mw), 32'd0);
    check_eq("rst_mid_state", 32'(tr_st.size() > 0 ? tr_st[0] : -1), 32'd0);
    check_eq("rst_mid_memerr", 32'(bus.memerr), 32'd0);

    // Randomized stream.
    begin
      logic [5:0] ops [10];
      logic [5:0] fns [6];
      bit picked = 0;
      bit slow   = 0;
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
              6'b001000, 6'b000010, 6'b001100, 6'b001101, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
      for (int c = 0; c < 4000; c++) begin
        if (m_st == 0 && !picked) begin
          picked    = 1;
          bus.op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
          bus.funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
          slow      = ($urandom_range(0, 4) == 0);
        end
        if (m_st != 0) picked = 0;
        bus.zero     = 1'($urandom);
        bus.memready = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 499) == 0) begin
          apply_reset($urandom_range(1, 2));
          picked = 0;
        end else begin
          tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
